// File: rtl/rom_lookup_sched.sv
// rom_lookup_sched: two-lane round-robin scheduler in front of a dual-port ROM with id tracking.
// Optional statistics counters are enabled with ROM_LOOKUP_SCHED_STATS_EN.
module rom_lookup_sched #(
  parameter int NREQ    = 4,
  parameter int MXADRB  = 12,
  parameter int MXDATB  = 9,
  parameter int ROM_LAT = 2,
  parameter int IDW     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*MXADRB-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic [MXADRB-1:0]        rom_addra,
  output logic [MXADRB-1:0]        rom_addrb,
  input  logic [MXDATB-1:0]        rom_douta,
  input  logic [MXDATB-1:0]        rom_doutb,
  output logic                     res_valid_a,
  output logic [IDW-1:0]           res_id_a,
  output logic [MXDATB-1:0]        res_data_a,
  output logic                     res_valid_b,
  output logic [IDW-1:0]           res_id_b,
  output logic [MXDATB-1:0]        res_data_b
`ifdef ROM_LOOKUP_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_grants,
  output logic [31:0]              stat_stalls
`endif
);
  logic [IDW-1:0] rr, rr_nxt, gid_a, gid_b, last;
  logic ga, gb;
  logic iva, ivb;
  logic [IDW-1:0] ida, idb;
  logic [ROM_LAT-1:0] vpa, vpb;
  logic [ROM_LAT-1:0][IDW-1:0] ipa, ipb;
  int idx;
  // scan from rr; first valid channel takes lane A, second takes lane B
  always_comb begin
    req_ready = '0;
    ga = 1'b0;
    gb = 1'b0;
    gid_a = '0;
    gid_b = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      idx = idx >= NREQ ? idx - NREQ : idx;
      if (!rst && req_valid[idx] && !gb) begin
        req_ready[idx] = 1'b1;
        if (!ga) begin
          ga = 1'b1;
          gid_a = IDW'(idx);
        end else begin
          gb = 1'b1;
          gid_b = IDW'(idx);
        end
      end
    end
    last = gb ? gid_b : gid_a;
    rr_nxt = !ga ? rr : (last == IDW'(NREQ - 1)) ? '0 : last + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
      rom_addra <= '0;
      rom_addrb <= '0;
      iva <= 1'b0;
      ivb <= 1'b0;
      ida <= '0;
      idb <= '0;
      vpa <= '0;
      vpb <= '0;
      ipa <= '0;
      ipb <= '0;
    end else begin
      rr <= rr_nxt;
      if (ga) rom_addra <= req_addr[gid_a*MXADRB +: MXADRB];
      if (gb) rom_addrb <= req_addr[gid_b*MXADRB +: MXADRB];
      iva <= ga;
      ivb <= gb;
      ida <= gid_a;
      idb <= gid_b;
      vpa[0] <= iva;
      vpb[0] <= ivb;
      ipa[0] <= ida;
      ipb[0] <= idb;
      for (int i = 1; i < ROM_LAT; i++) begin
        vpa[i] <= vpa[i-1];
        vpb[i] <= vpb[i-1];
        ipa[i] <= ipa[i-1];
        ipb[i] <= ipb[i-1];
      end
    end
  end
  assign res_valid_a = vpa[ROM_LAT-1];
  assign res_valid_b = vpb[ROM_LAT-1];
  assign res_id_a = ipa[ROM_LAT-1];
  assign res_id_b = ipb[ROM_LAT-1];
  assign res_data_a = rom_douta;
  assign res_data_b = rom_doutb;
`ifdef ROM_LOOKUP_SCHED_STATS_EN
  logic [32:0] gsum;
  logic stall;
  assign gsum = {1'b0, stat_grants} + 33'(ga) + 33'(gb);
  assign stall = |(req_valid & ~req_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      stat_grants <= gsum[32] ? '1 : gsum[31:0];
      stat_stalls <= (stall && !(&stat_stalls)) ? stat_stalls + 1 : stat_stalls;
    end
  end
`endif
endmodule
